// File: rtl/lsu_pkg.sv
// Shared types and constants for the d16 load/store unit.
package lsu_pkg;
  localparam int LSU_ADDR_W = 16;
  localparam int DATA_W     = 16;

  typedef enum logic [1:0] {IDLE, ISSUE, DATA, RESP} state_t;
endpackage

// File: rtl/lsu_rdata_fmt.sv
// Load data formatting: byte reads arrive in the low lane and are zero- or
// sign-extended to a full word; word reads pass through.
module lsu_rdata_fmt
  import lsu_pkg::*;
(
  input  logic [DATA_W-1:0] rdata,
  input  logic              byte_acc,
  input  logic              sign_ext,
  output logic [DATA_W-1:0] fmt_data
);
  logic signed [7:0]        byte_s;
  logic signed [DATA_W-1:0] byte_sx;

  always_comb begin
    byte_s  = rdata[7:0];
    byte_sx = sign_ext ? DATA_W'(byte_s) : DATA_W'({1'b0, rdata[7:0]});
    fmt_data = byte_acc ? byte_sx : rdata;
  end
endmodule

// File: rtl/lsu.sv
// Load/store unit: one byte-addressed request at a time onto the word-addressed
// d16 memory port. Define LSU_ALIGN_CHECK_EN to fault misaligned word accesses.
module lsu
  import lsu_pkg::*;
#(
  parameter int ADDR_W = LSU_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic              req_byte,
  input  logic              req_signed,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_fault,
  output logic              mem_en,
  output logic              mem_write_enable,
  output logic              mem_byte_enable,
  output logic              mem_byte_select,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_wait
);
  state_t            state, state_next;
  logic              sign_q, sign_next;
  logic              mem_en_next, mem_we_next, mem_be_next, mem_bs_next;
  logic [ADDR_W-1:0] mem_addr_next;
  logic [DATA_W-1:0] mem_wdata_next;
  logic              resp_valid_next, resp_fault_next;
  logic [DATA_W-1:0] resp_rdata_next;
  logic [DATA_W-1:0] fmt_data;
  logic              misaligned;

`ifdef LSU_ALIGN_CHECK_EN
  assign misaligned = ~req_byte & req_addr[0];
`else
  assign misaligned = 1'b0;
`endif

  lsu_rdata_fmt u_fmt (
    .rdata    (mem_rdata),
    .byte_acc (mem_byte_enable),
    .sign_ext (sign_q),
    .fmt_data (fmt_data)
  );

  assign req_ready = (state == IDLE);

  always_comb begin
    state_next      = state;
    sign_next       = sign_q;
    mem_en_next     = mem_en;
    mem_we_next     = mem_write_enable;
    mem_be_next     = mem_byte_enable;
    mem_bs_next     = mem_byte_select;
    mem_addr_next   = mem_addr;
    mem_wdata_next  = mem_wdata;
    resp_valid_next = resp_valid;
    resp_fault_next = resp_fault;
    resp_rdata_next = resp_rdata;
    case (state)
      IDLE: begin
        if (req_valid) begin
          sign_next      = req_signed;
          mem_we_next    = req_write;
          mem_be_next    = req_byte;
          mem_bs_next    = req_addr[0];
          mem_addr_next  = {1'b0, req_addr[ADDR_W-1:1]};
          mem_wdata_next = req_wdata;
          if (misaligned) begin
            state_next      = RESP;
            resp_valid_next = 1'b1;
            resp_fault_next = 1'b1;
            resp_rdata_next = '0;
          end else begin
            state_next  = ISSUE;
            mem_en_next = 1'b1;
          end
        end
      end
      ISSUE: begin
        if (!mem_wait) begin
          mem_en_next = 1'b0;
          if (mem_write_enable) begin
            state_next      = RESP;
            resp_valid_next = 1'b1;
            resp_fault_next = 1'b0;
            resp_rdata_next = '0;
          end else begin
            state_next = DATA;
          end
        end
      end
      DATA: begin
        if (!mem_wait) begin
          state_next      = RESP;
          resp_valid_next = 1'b1;
          resp_fault_next = 1'b0;
          resp_rdata_next = fmt_data;
        end
      end
      RESP: begin
        if (resp_ready) begin
          state_next      = IDLE;
          resp_valid_next = 1'b0;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Every output except req_ready is registered; reset clears the data side too.
  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= IDLE;
      sign_q           <= 1'b0;
      mem_en           <= 1'b0;
      mem_write_enable <= 1'b0;
      mem_byte_enable  <= 1'b0;
      mem_byte_select  <= 1'b0;
      mem_addr         <= '0;
      mem_wdata        <= '0;
      resp_valid       <= 1'b0;
      resp_fault       <= 1'b0;
      resp_rdata       <= '0;
    end else begin
      state            <= state_next;
      sign_q           <= sign_next;
      mem_en           <= mem_en_next;
      mem_write_enable <= mem_we_next;
      mem_byte_enable  <= mem_be_next;
      mem_byte_select  <= mem_bs_next;
      mem_addr         <= mem_addr_next;
      mem_wdata        <= mem_wdata_next;
      resp_valid       <= resp_valid_next;
      resp_fault       <= resp_fault_next;
      resp_rdata       <= resp_rdata_next;
    end
  end
endmodule
